// File: rtl/dma_busmaster.sv
// Object DMA bus master: on a CPU trigger, waits for vertical blank, takes the Z80 bus
// and copies NBYTES of object RAM into the DMA object buffer, one byte per RD_WAIT+1 CEN ticks.
module dma_busmaster #(
    parameter int          AW      = 10,
    parameter int          NBYTES  = 1024,
    parameter logic [11:0] BASE    = 12'h000,
    parameter int          RD_WAIT = 2
) (
    input  logic          CLK20,
    input  logic          RESETn,
    input  logic          CEN,
    input  logic          VB,
    input  logic          DWRBKn,
    input  logic          BUSAK_n,
    input  logic [7:0]    DD_IN,
    output logic          BUSRQn,
    output logic [11:0]   AD,
    output logic          AD_OE,
    output logic          RDn,
    output logic [AW-1:0] DM_A,
    output logic [7:0]    DM_D,
    output logic          DM_WEn,
    output logic          BUSY,
    output logic          DONE
);

    localparam int            WW    = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
    localparam logic [AW-1:0] LAST  = AW'(NBYTES - 1);
    localparam logic [WW-1:0] WLAST = WW'(RD_WAIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_LATCH, S_REL} state_t;

    state_t        r_state, w_state;
    logic          r_busrqn, w_busrqn;
    logic [11:0]   r_ad, w_ad;
    logic          r_adoe, w_adoe;
    logic          r_rdn, w_rdn;
    logic [AW-1:0] r_dma, w_dma;
    logic [7:0]    r_dmd, w_dmd;
    logic          r_dmwen, w_dmwen;
    logic          r_busy, w_busy;
    logic          r_done, w_done;
    logic [AW-1:0] r_count, w_count;
    logic [WW-1:0] r_wait, w_wait;
    logic          r_abort, w_abort;
    logic          w_pend_clr, w_pend_set;

    logic r_pending;
    logic r_dwr_d1, r_dwr_d2;
    logic r_vb_d1, r_vb_d2, r_vb_rise, r_vb_fall;
    logic r_ak_s1, r_ak_s2;

    logic          w_trig, w_vb_rise, w_vb_fall, w_ack;
    logic [AW-1:0] w_count_inc;

    assign w_trig      = r_dwr_d2 & ~r_dwr_d1;
    assign w_vb_rise   = r_vb_rise | (r_vb_d1 & ~r_vb_d2);
    assign w_vb_fall   = r_vb_fall | (~r_vb_d1 & r_vb_d2);
    assign w_ack       = ~r_ak_s2;
    assign w_count_inc = r_count + AW'(1);

    // Edge detectors and the ack synchroniser run every CLK20; VB edges are held until a CEN tick sees them.
    always_ff @(posedge CLK20 or negedge RESETn) begin
        if (!RESETn) begin
            r_dwr_d1  <= 1'b1;
            r_dwr_d2  <= 1'b1;
            r_vb_d1   <= 1'b0;
            r_vb_d2   <= 1'b0;
            r_vb_rise <= 1'b0;
            r_vb_fall <= 1'b0;
            r_ak_s1   <= 1'b1;
            r_ak_s2   <= 1'b1;
            r_pending <= 1'b0;
        end else begin
            r_dwr_d1  <= DWRBKn;
            r_dwr_d2  <= r_dwr_d1;
            r_vb_d1   <= VB;
            r_vb_d2   <= r_vb_d1;
            r_vb_rise <= CEN ? 1'b0 : w_vb_rise;
            r_vb_fall <= CEN ? 1'b0 : w_vb_fall;
            r_ak_s1   <= BUSAK_n;
            r_ak_s2   <= r_ak_s1;
            r_pending <= (r_pending & ~(CEN & w_pend_clr)) | (CEN & w_pend_set) | w_trig;
        end
    end

    always_ff @(posedge CLK20 or negedge RESETn) begin
        if (!RESETn) begin
            r_state  <= S_IDLE;
            r_busrqn <= 1'b1;
            r_ad     <= BASE;
            r_adoe   <= 1'b0;
            r_rdn    <= 1'b1;
            r_dma    <= '0;
            r_dmd    <= '0;
            r_dmwen  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_count  <= '0;
            r_wait   <= '0;
            r_abort  <= 1'b0;
        end else if (CEN) begin
            r_state  <= w_state;
            r_busrqn <= w_busrqn;
            r_ad     <= w_ad;
            r_adoe   <= w_adoe;
            r_rdn    <= w_rdn;
            r_dma    <= w_dma;
            r_dmd    <= w_dmd;
            r_dmwen  <= w_dmwen;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_count  <= w_count;
            r_wait   <= w_wait;
            r_abort  <= w_abort;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_busrqn   = r_busrqn;
        w_ad       = r_ad;
        w_adoe     = r_adoe;
        w_rdn      = r_rdn;
        w_dma      = r_dma;
        w_dmd      = r_dmd;
        w_dmwen    = 1'b1;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_count    = r_count;
        w_wait     = r_wait;
        w_abort    = r_abort;
        w_pend_clr = 1'b0;
        w_pend_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pending && w_vb_rise) begin
                    w_state    = S_REQ;
                    w_busrqn   = 1'b0;
                    w_busy     = 1'b1;
                    w_abort    = 1'b0;
                    w_pend_clr = 1'b1;
                end
            end
            S_REQ: begin
                if (w_ack) begin
                    w_state = S_ADDR;
                    w_adoe  = 1'b1;
                    w_ad    = BASE;
                    w_dma   = '0;
                    w_count = '0;
                    w_wait  = '0;
                    w_rdn   = 1'b0;
                end else if (w_vb_fall) begin
                    // Missed this blank; give the bus request back and retry next frame.
                    w_state    = S_IDLE;
                    w_busrqn   = 1'b1;
                    w_busy     = 1'b0;
                    w_pend_set = 1'b1;
                end
            end
            S_ADDR, S_LATCH: begin
                if (!w_ack) begin
                    w_state    = S_REL;
                    w_adoe     = 1'b0;
                    w_rdn      = 1'b1;
                    w_busrqn   = 1'b1;
                    w_abort    = 1'b1;
                    w_pend_set = 1'b1;
                end else if (r_state == S_ADDR) begin
                    if (r_wait == WLAST) begin
                        w_state = S_LATCH;
                        w_dmd   = DD_IN;
                        w_dmwen = 1'b0;
                        w_dma   = r_count;
                        w_rdn   = 1'b1;
                    end else begin
                        w_wait = r_wait + WW'(1);
                    end
                end else if (r_count == LAST) begin
                    w_state  = S_REL;
                    w_adoe   = 1'b0;
                    w_busrqn = 1'b1;
                end else begin
                    w_state = S_ADDR;
                    w_count = w_count_inc;
                    w_ad    = BASE + 12'(w_count_inc);
                    w_wait  = '0;
                    w_rdn   = 1'b0;
                end
            end
            S_REL: begin
                if (!w_ack) begin
                    w_state = S_IDLE;
                    w_busy  = 1'b0;
                    w_done  = ~r_abort;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign BUSRQn = r_busrqn;
    assign AD     = r_ad;
    assign AD_OE  = r_adoe;
    assign RDn    = r_rdn;
    assign DM_A   = r_dma;
    assign DM_D   = r_dmd;
    assign DM_WEn = r_dmwen;
    assign BUSY   = r_busy;
    assign DONE   = r_done;

endmodule
